uart_rx: RTL and testbench

Serial receiver for the team's 8N1 UART link; the receiving end of the line driven by `uart_tx`. It synchronises the asynchronous serial input and validates the start bit at mid-bit. It then samples 8 data bits LSB-first at bit centres, checks the stop bit, and presents each byte with a one-cycle valid pulse. It sits between the pad-side serial input and the byte-level consumer, normally a FIFO or command decoder.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx.sv | 114 +++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry for the rx/tx pair.
// No logic; combinational constants only, no flow control.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an async input, plus one further delayed copy for edge detection.
// Latency 2 cycles to q, 3 to q_prev; no backpressure (free-running).
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_prev
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= RESET_VAL;
      q      <= RESET_VAL;
      q_prev <= RESET_VAL;
    end else begin
      meta   <= d;
      q      <= meta;
      q_prev <= q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, LSB-first data sampling, stop check, 1-cycle valid/error pulses.
// Latency CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 4 cycles from line fall to rx_valid; no backpressure (consumer must accept each pulse).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic             s_line;
  logic             s_prev;
  logic             fall;
  uart_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       rx_data_nxt;
  logic             valid_nxt;
  logic             err_nxt;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (rx_serial),
    .q      (s_line),
    .q_prev (s_prev)
  );

  // Edge rather than level, so a held-low line (break) cannot restart a frame.
  assign fall    = !s_line && s_prev;
  assign rx_busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    rx_data_nxt = rx_data;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          if (!s_line) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = s_line;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid-stop so the next start edge has half a bit of slack.
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (s_line) begin
            rx_data_nxt = shift;
            valid_nxt   = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shift        <= shift_nxt;
      rx_data      <= rx_data_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized 8N1 traffic at nominal and +/-3% baud.
// The line is driven in absolute time, independent of the DUT clock, like a real remote transmitter.
module tb_uart_rx;

  localparam int N      = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = N * CLK_NS;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc = 0, vld_cnt = 0, err_cnt = 0, both_cnt = 0, busy_cnt = 0, last_vld_cyc = -1000;
  logic [7:0] got_q[$];
  logic [7:0] last_good;
  int bauds[3] = '{160, 155, 165};

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vld_cnt++;
      got_q.push_back(rx_data);
      last_vld_cyc = cyc;
    end
    if (rx_frame_err) err_cnt++;
    if (rx_valid && rx_frame_err) both_cnt++;
    if (rx_busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx_serial = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      #(bit_ns);
    end
    rx_serial = stop_bit;
    #(bit_ns);
  endtask

  // Reference rule: a good stop bit yields exactly one valid pulse and updates the held byte;
  // a bad stop bit yields exactly one error pulse and leaves the held byte alone.
  task automatic check_frame(input string tag, input logic [7:0] b, input logic stop_bit,
                             input int v0, input int e0);
    if (stop_bit) last_good = b;
    chk({tag, "_vld"},  32'(vld_cnt - v0), stop_bit ? 32'd1 : 32'd0);
    chk({tag, "_err"},  32'(err_cnt - e0), stop_bit ? 32'd0 : 32'd1);
    chk({tag, "_data"}, 32'(rx_data), 32'(last_good));
    chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    int v0, e0, t0, lat, b0, bit_ns, gap;
    logic [7:0] b, g0, g1;
    logic stop_bit;

    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_err",   32'(rx_frame_err), 32'd0);
    chk("rst_busy",  32'(rx_busy), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (N) @(posedge clk);

    // 0x55 with end-to-end latency
    @(posedge clk);
    #1;
    t0 = cyc; v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    lat = last_vld_cyc - t0;
    chk("lat_window", 32'((lat >= N / 2 + 9 * N + 3) && (lat <= N / 2 + 9 * N + 5)), 32'd1);
    check_frame("f55", 8'h55, 1'b1, v0, e0);

    // 0xA3: LSB-first ordering and busy duration from START entry to stop sample
    v0 = vld_cnt; e0 = err_cnt; b0 = busy_cnt;
    send_frame(8'hA3, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    check_frame("fa3", 8'hA3, 1'b1, v0, e0);
    chk("fa3_busy_cycles", 32'(busy_cnt - b0), 32'(N / 2 + 9 * N));

    // Short low glitch: rejected at mid-start, busy only for the half bit
    v0 = vld_cnt; e0 = err_cnt; b0 = busy_cnt;
    rx_serial = 1'b0;
    #(N / 4 * CLK_NS);
    rx_serial = 1'b1;
    #(2 * BIT_NS);
    chk("glitch_vld",  32'(vld_cnt - v0), 32'd0);
    chk("glitch_err",  32'(err_cnt - e0), 32'd0);
    chk("glitch_data", 32'(rx_data), 32'(last_good));
    chk("glitch_busy", 32'(rx_busy), 32'd0);
    chk("glitch_busy_cycles", 32'(busy_cnt - b0), 32'(N / 2));

    // Framing error followed by a 40-bit break: one error, no retrigger
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, BIT_NS);
    b0 = busy_cnt;
    #(40 * BIT_NS);
    check_frame("f3c_brk", 8'h3C, 1'b0, v0, e0);
    chk("break_no_retrigger", 32'(busy_cnt - b0), 32'd0);
    rx_serial = 1'b1;
    #(2 * BIT_NS);

    // Back-to-back 0x00 / 0xFF at nominal, +3% and -3% baud
    for (int k = 0; k < 3; k++) begin
      bit_ns = bauds[k];
      got_q.delete();
      v0 = vld_cnt; e0 = err_cnt;
      send_frame(8'h00, 1'b1, bit_ns);
      send_frame(8'hFF, 1'b1, bit_ns);
      #(2 * bit_ns);
      g0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      g1 = (got_q.size() > 1) ? got_q[1] : 8'hxx;
      chk($sformatf("b2b%0d_count", k), 32'(vld_cnt - v0), 32'd2);
      chk($sformatf("b2b%0d_first", k), 32'(g0), 32'h00);
      chk($sformatf("b2b%0d_second", k), 32'(g1), 32'hFF);
      chk($sformatf("b2b%0d_err", k), 32'(err_cnt - e0), 32'd0);
      last_good = 8'hFF;
    end

    // Reset during data bit 4 of 0xF0, released mid-frame; remaining bits are high
    v0 = vld_cnt; e0 = err_cnt;
    rx_serial = 1'b0;
    #(5 * BIT_NS);
    rx_serial = 1'b1;
    #(BIT_NS / 2);
    chk("pre_rst_busy", 32'(rx_busy), 32'd1);
    @(negedge clk) rst = 1'b0;
    #2;
    chk("arst_data",  32'(rx_data), 32'h00);
    chk("arst_valid", 32'(rx_valid), 32'd0);
    chk("arst_err",   32'(rx_frame_err), 32'd0);
    chk("arst_busy",  32'(rx_busy), 32'd0);
    last_good = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #(5 * BIT_NS);
    chk("abort_vld", 32'(vld_cnt - v0), 32'd0);
    chk("abort_err", 32'(err_cnt - e0), 32'd0);
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h81, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    check_frame("f81", 8'h81, 1'b1, v0, e0);

    // Randomized traffic: random byte, stop bit, baud and idle gap
    for (int k = 0; k < 24; k++) begin
      b        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 3) != 0);
      bit_ns   = bauds[$urandom_range(0, 2)];
      gap      = $urandom_range(stop_bit ? 0 : 1, 3);
      v0 = vld_cnt; e0 = err_cnt;
      send_frame(b, stop_bit, bit_ns);
      rx_serial = 1'b1;
      #(gap * bit_ns);
      check_frame($sformatf("rnd%0d", k), b, stop_bit, v0, e0);
    end
    #(2 * BIT_NS);

    chk("valid_err_overlap", 32'(both_cnt), 32'd0);
    chk("pulses_total", 32'(got_q.size() > 0), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
